// File: rtl/instr_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue_if
// Handshake bundle between the fetch stage (IF), the instruction queue and
// the decode stage (ID).
//
// Signals:
//   enq_valid  IF presents a {PC, instruction} entry
//   enq_data   entry payload; [63:32] = PC, [31:0] = instruction
//   enq_ready  queue will accept the entry this cycle
//   deq_ready  ID consumes the head entry this cycle
//   deq_valid  head entry is valid
//   deq_data   head entry payload
//
// Modports:
//   master  the pipeline side (IF producer + ID consumer)
//   slave   the queue itself
// ---------------------------------------------------------------------------
interface instr_fetch_queue_if #(
    parameter int WIDTH = 64
);
    logic             enq_valid;
    logic [WIDTH-1:0] enq_data;
    logic             enq_ready;
    logic             deq_ready;
    logic             deq_valid;
    logic [WIDTH-1:0] deq_data;

    modport master (
        output enq_valid,
        output enq_data,
        input  enq_ready,
        output deq_ready,
        input  deq_valid,
        input  deq_data
    );

    modport slave (
        input  enq_valid,
        input  enq_data,
        output enq_ready,
        input  deq_ready,
        output deq_valid,
        output deq_data
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
// Circular FIFO between IF and ID so fetch and decode can run decoupled.
// Each entry is {PC[31:0], instruction[31:0]}. The head entry is presented
// combinationally (first-word fall-through); a freshly written entry becomes
// visible only after the edge that stores it.
//
// Ports:
//   CLK     clock, all state changes on the rising edge
//   RESET   synchronous active-high reset
//   flush   discard every entry (driven by the alternate-PC request)
//   bus     slave side of instr_fetch_queue_if (enq/deq handshakes)
//   count   current occupancy, 0..DEPTH
//   halt    IF must hold its PC because the queue is full
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  flush,
    instr_fetch_queue_if.slave    bus,
    output logic [CNT_W-1:0]      count,
    output logic                  halt
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             enqFire;
    logic             deqFire;

    // Status outputs come only from the registered occupancy so that there is
    // no combinational path from deq_ready back to the fetch stage, and no X
    // can reach the control outputs through the storage array.
    always_comb begin
        bus.enq_ready = (count != CNT_W'(DEPTH));
        bus.deq_valid = (count != '0);
        halt          = (count == CNT_W'(DEPTH));
        bus.deq_data  = mem[head];
    end

    // A flush cancels any handshake in the same cycle, so both fires are
    // gated by it; the redirect wins over whatever IF/ID were doing.
    always_comb begin
        enqFire = bus.enq_valid & bus.enq_ready & ~flush;
        deqFire = bus.deq_valid & bus.deq_ready & ~flush;
    end

    // Storage array: written only on an accepted enqueue. Contents are left
    // alone on reset/flush because the pointers alone define what is valid.
    always_ff @(posedge CLK) begin
        if (!RESET && enqFire) begin
            mem[tail] <= bus.enq_data;
        end
    end

    // Pointers and occupancy. Pointers are exactly log2(DEPTH) bits wide so
    // they wrap from DEPTH-1 to 0 on their own; count carries the extra bit
    // that distinguishes full from empty when head == tail.
    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enqFire) begin
                tail <= tail + PTR_W'(1);
            end
            if (deqFire) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(enqFire) - CNT_W'(deqFire);
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_queue
// Directed bench for instr_fetch_queue: a table of per-cycle vectors for
// reset / fill / overfill / drain, followed by hand-written sequences for
// streaming with wrap-around, full-plus-dequeue, flush and mid-stream reset.
// Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_queue;
    localparam int DEPTH = 8;
    localparam int WIDTH = 64;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct {
        string       name;
        logic        rst;
        logic        fl;
        logic        enqV;
        logic [31:0] enqPc;
        logic        deqR;
        int          expCount;
        logic        chkHead;
        logic [31:0] expPc;
    } vector_t;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             flush;
    logic [CNT_W-1:0] count;
    logic             halt;

    int checks = 0;
    int passes = 0;

    vector_t vecs[$];

    instr_fetch_queue_if #(.WIDTH(WIDTH)) bus ();

    instr_fetch_queue #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .flush(flush),
        .bus  (bus),
        .count(count),
        .halt (halt)
    );

    // Free-running clock, period 10.
    always #5 CLK = ~CLK;

    // The instruction word is derived from the PC so the whole 64-bit entry
    // can be checked from a PC alone.
    function automatic logic [63:0] makeEntry(input logic [31:0] pc);
        return {pc, ~pc ^ 32'h1357_9BDF};
    endfunction

    task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    // Compare every output against what the given occupancy implies, plus
    // the head entry when one is expected.
    task automatic checkOutput(input string name, input int expCount,
                               input logic chkHead, input logic [31:0] expPc);
        checkEq({name, " count"}, 64'(count), 64'(expCount));
        checkEq({name, " deq_valid"}, 64'(bus.deq_valid), 64'(expCount != 0));
        checkEq({name, " enq_ready"}, 64'(bus.enq_ready), 64'(expCount != DEPTH));
        checkEq({name, " halt"}, 64'(halt), 64'(expCount == DEPTH));
        if (chkHead) begin
            checkEq({name, " deq_data"}, bus.deq_data, makeEntry(expPc));
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, and return 1 unit after.
    task automatic applyStimulus(input logic rst, input logic fl, input logic enqV,
                                 input logic [31:0] enqPc, input logic deqR);
        RESET         = rst;
        flush         = fl;
        bus.enq_valid = enqV;
        bus.enq_data  = makeEntry(enqPc);
        bus.deq_ready = deqR;
        @(posedge CLK);
        #1;
    endtask

    task automatic addVec(input string name, input logic rst, input logic fl,
                          input logic enqV, input logic [31:0] enqPc, input logic deqR,
                          input int expCount, input logic chkHead, input logic [31:0] expPc);
        vector_t v;
        v.name = name; v.rst = rst; v.fl = fl; v.enqV = enqV; v.enqPc = enqPc;
        v.deqR = deqR; v.expCount = expCount; v.chkHead = chkHead; v.expPc = expPc;
        vecs.push_back(v);
    endtask

    // Fill n entries starting at basePc with ID stalled.
    task automatic fillQueue(input string name, input logic [31:0] basePc, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, basePc + 32'(4 * i), 1'b0);
        end
        checkOutput(name, n, 1'b1, basePc);
    endtask

    // Pop n entries, checking the head before each pop.
    task automatic drainExpect(input string name, input logic [31:0] basePc, input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput(name, n - i, 1'b1, basePc + 32'(4 * i));
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        end
        checkOutput({name, " empty"}, 0, 1'b0, 32'h0);
    endtask

    initial begin
        RESET         = 1'b1;
        flush         = 1'b0;
        bus.enq_valid = 1'b0;
        bus.enq_data  = '0;
        bus.deq_ready = 1'b0;

        // Reset with enq_valid high: nothing may be captured.
        addVec("reset1", 1, 0, 1, 32'h0040_0000, 0, 0, 0, 32'h0);
        addVec("reset2", 1, 0, 1, 32'h0040_0000, 0, 0, 0, 32'h0);
        // Fill eight entries; head stays on the first PC throughout.
        for (int i = 0; i < DEPTH; i++) begin
            addVec("fill", 0, 0, 1, 32'h0040_0000 + 32'(4 * i), 0, i + 1, 1, 32'h0040_0000);
        end
        // Ninth enqueue while full is ignored.
        addVec("overfill", 0, 0, 1, 32'h0040_0020, 0, DEPTH, 1, 32'h0040_0000);
        // Drain; head walks through the PCs in order.
        for (int k = 0; k < DEPTH; k++) begin
            addVec("drain", 0, 0, 0, 32'h0, 1, DEPTH - 1 - k, (k < DEPTH - 1),
                   32'h0040_0000 + 32'(4 * (k + 1)));
        end
        // Dequeue request while empty has no effect.
        addVec("underflow", 0, 0, 0, 32'h0, 1, 0, 0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].fl, vecs[i].enqV, vecs[i].enqPc, vecs[i].deqR);
            checkOutput(vecs[i].name, vecs[i].expCount, vecs[i].chkHead, vecs[i].expPc);
        end

        // Streaming: four entries resident, then enqueue and dequeue together
        // for 20 cycles; 24 pushes total wrap the pointers three times.
        fillQueue("stream prefill", 32'h0050_0000, 4);
        for (int c = 0; c < 20; c++) begin
            checkOutput("stream head", 4, 1'b1, 32'h0050_0000 + 32'(4 * c));
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h0050_0000 + 32'(4 * (c + 4)), 1'b1);
        end
        drainExpect("stream drain", 32'h0050_0000 + 32'(4 * 20), 4);

        // Full plus dequeue: the dequeue proceeds, the enqueue is refused,
        // then accepted on the following cycle.
        fillQueue("full prefill", 32'h0060_0000, DEPTH);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0060_0020, 1'b1);
        checkOutput("full+deq", DEPTH - 1, 1'b1, 32'h0060_0004);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0060_0020, 1'b0);
        checkOutput("full refill", DEPTH, 1'b1, 32'h0060_0004);
        drainExpect("full drain", 32'h0060_0004, DEPTH);

        // Flush with both handshakes active: everything is dropped and the
        // next enqueue becomes the first dequeued entry.
        fillQueue("flush prefill", 32'h0070_0000, 5);
        RESET         = 1'b0;
        flush         = 1'b1;
        bus.enq_valid = 1'b1;
        bus.enq_data  = makeEntry(32'h0070_00AA);
        bus.deq_ready = 1'b1;
        @(posedge CLK);
        #1;
        flush = 1'b0;
        checkOutput("flush", 0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0040_0100, 1'b0);
        checkOutput("after flush", 1, 1'b1, 32'h0040_0100);
        drainExpect("after flush drain", 32'h0040_0100, 1);

        // Reset in the middle of traffic, then normal operation resumes.
        fillQueue("rst prefill", 32'h0080_0000, 3);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0080_00CC, 1'b1);
        checkOutput("mid reset", 0, 1'b0, 32'h0);
        fillQueue("post reset fill", 32'h0090_0000, 2);
        drainExpect("post reset drain", 32'h0090_0000, 2);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
